// File: rtl/mips_dmem_ctrl.sv
// Data memory for the pipelined MIPS core: byte/half/word loads and stores with extension,
// programmable wait states signalled through Stall, misalignment flagging and a debug read port.
module mips_dmem_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int LATENCY    = 2
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Stall,
  output logic                  Done,
  output logic                  MisalignErr,
  input  logic [ADDR_WIDTH-1:0] DispReadMem,
  output logic [31:0]           DispMemData
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0] CNT_LOAD = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  capture;
  logic                  done_c;

  logic                  req_rd_q, req_wr_q, uns_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rd_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  a_rd, a_wr, a_uns, a_ld, a_mis, commit;
  logic [1:0]            a_size;
  logic [ADDR_WIDTH+1:0] a_addr;
  logic [ADDR_WIDTH-1:0] a_widx;
  logic [31:0]           a_wdata, rword, ext_val, ld_val, wval;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [3:0]            wmask;

  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr[31:ADDR_WIDTH+2];

  // In IDLE the live request is used (zero-latency completion); afterwards the captured copy,
  // so a request dropped mid-access still finishes as originally issued.
  always_comb begin
    a_rd    = MemRead;
    a_wr    = MemWrite;
    a_size  = Size;
    a_uns   = Unsigned;
    a_addr  = Addr[ADDR_WIDTH+1:0];
    a_wdata = WriteData;
    if (state_q != S_IDLE) begin
      a_rd    = req_rd_q;
      a_wr    = req_wr_q;
      a_size  = size_q;
      a_uns   = uns_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  assign a_ld   = a_rd & ~a_wr;
  assign a_widx = a_addr[ADDR_WIDTH+1:2];
  assign rword  = mem_q[a_widx];
  assign rbyte  = rword[{a_addr[1:0], 3'b000} +: 8];
  assign rhalf  = rword[{a_addr[1], 4'b0000} +: 16];

  always_comb begin
    a_mis   = 1'b0;
    ext_val = rword;
    wval    = a_wdata;
    wmask   = 4'b1111;
    case (a_size)
      2'b00: begin
        ext_val = {{24{rbyte[7] & ~a_uns}}, rbyte};
        wval    = {4{a_wdata[7:0]}};
        wmask   = 4'b0001 << a_addr[1:0];
      end
      2'b01: begin
        a_mis   = a_addr[0];
        ext_val = {{16{rhalf[15] & ~a_uns}}, rhalf};
        wval    = {2{a_wdata[15:0]}};
        wmask   = a_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: a_mis = |a_addr[1:0];
    endcase
  end

  assign ld_val = (a_ld & ~a_mis) ? ext_val : 32'd0;

  // WAIT spans LATENCY-1 cycles; the counter reaches 0 exactly as DONE is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Stall   = 1'b0;
    done_c  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemRead | MemWrite) begin
          if (LATENCY == 0) begin
            done_c = 1'b1;
          end else begin
            Stall   = 1'b1;
            capture = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        Stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign commit      = done_c & a_wr & ~a_mis;
  assign Done        = done_c;
  assign MisalignErr = done_c & a_mis;
  assign ReadData    = done_c ? ld_val : rd_q;
  assign DispMemData = mem_q[DispReadMem];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      req_rd_q <= 1'b0;
      req_wr_q <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rd_q     <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        req_rd_q <= MemRead;
        req_wr_q <= MemWrite;
        uns_q    <= Unsigned;
        size_q   <= Size;
        addr_q   <= Addr[ADDR_WIDTH+1:0];
        wdata_q  <= WriteData;
      end
      if (done_c & a_ld) rd_q <= ld_val;
      if (commit) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) mem_q[a_widx][8*b +: 8] <= wval[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Bench for mips_dmem_ctrl: three instances (LATENCY 0, 2, 3) share data inputs; requests are
// steered to one instance at a time. Table-driven accesses plus directed multi-cycle sequences.
module tb_mips_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr, mw, uns;
  logic [1:0]  size;
  logic [1:0]  sel;
  logic [31:0] addr, wdata;
  logic [5:0]  disp_idx;

  logic [2:0]  stall_w, done_w, mis_w;
  logic [31:0] rd_w   [3];
  logic [31:0] disp_w [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_dmem_ctrl #(.ADDR_WIDTH(6), .LATENCY(0)) u_l0 (
    .CLK(clk), .Reset(rst), .MemRead(mr & (sel == 2'd0)), .MemWrite(mw & (sel == 2'd0)),
    .Size(size), .Unsigned(uns), .Addr(addr), .WriteData(wdata), .ReadData(rd_w[0]),
    .Stall(stall_w[0]), .Done(done_w[0]), .MisalignErr(mis_w[0]),
    .DispReadMem(disp_idx), .DispMemData(disp_w[0]));

  mips_dmem_ctrl #(.ADDR_WIDTH(6), .LATENCY(2)) u_l2 (
    .CLK(clk), .Reset(rst), .MemRead(mr & (sel == 2'd1)), .MemWrite(mw & (sel == 2'd1)),
    .Size(size), .Unsigned(uns), .Addr(addr), .WriteData(wdata), .ReadData(rd_w[1]),
    .Stall(stall_w[1]), .Done(done_w[1]), .MisalignErr(mis_w[1]),
    .DispReadMem(disp_idx), .DispMemData(disp_w[1]));

  mips_dmem_ctrl #(.ADDR_WIDTH(6), .LATENCY(3)) u_l3 (
    .CLK(clk), .Reset(rst), .MemRead(mr & (sel == 2'd2)), .MemWrite(mw & (sel == 2'd2)),
    .Size(size), .Unsigned(uns), .Addr(addr), .WriteData(wdata), .ReadData(rd_w[2]),
    .Stall(stall_w[2]), .Done(done_w[2]), .MisalignErr(mis_w[2]),
    .DispReadMem(disp_idx), .DispMemData(disp_w[2]));

  typedef struct {
    logic        r;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one access to instance k and follows it to Done (bounded). A Stall seen together
  // with Done adds 100 so that the stall-count comparison catches it.
  task automatic access(input int k, input logic r, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int stalls,
                        output logic seen);
    mr = r; mw = w; size = sz; uns = u; addr = a; wdata = wd; sel = 2'(k);
    stalls = 0; seen = 1'b0; rd = 32'd0; mis = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done_w[k]) begin
        seen = 1'b1;
        rd   = rd_w[k];
        mis  = mis_w[k];
        if (stall_w[k]) stalls += 100;
      end else if (stall_w[k]) begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    mr = 1'b0; mw = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, last_ld, acc;
    logic        mis, seen;
    int          stalls, cyc;

    vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h20,  32'h80FF7F01, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h80FF7F01, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h22,  32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h23,  32'h0,        32'h00000080, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'hFFFF80FF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h20,  32'h0,        32'h00007F01, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h21,  32'h123456AA, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h80FFAA01, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h21,  32'h0,        32'hFFFFFFAA, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h22,  32'hCAFEBEEF, 32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h20,  32'h0,        32'hBEEFAA01, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        32'h0000BEEF, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h04,  32'h11111111, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h06,  32'hDEADBEEF, 32'h00000000, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h04,  32'h0,        32'h11111111, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h01,  32'h0,        32'h00000000, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h03,  32'h0,        32'h00000000, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'h5A5A5A5A, 32'h00000000, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h04,  32'h0,        32'h5A5A5A5A, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h08,  32'h00000077, 32'h00000000, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h08,  32'h0,        32'h00000077, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h20,  32'h0,        32'h00000001, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h23,  32'h0000FFFF, 32'h00000000, 1'b1};
    vecs[23] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'hBEEFAA01, 1'b0};

    // clock/reset
    rst = 1'b1; mr = 1'b0; mw = 1'b0; uns = 1'b0; size = 2'b10; sel = 2'd0;
    addr = 32'd0; wdata = 32'd0; disp_idx = 6'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_stall%0d", k), {31'd0, stall_w[k]}, 32'd0);
      check($sformatf("reset_done%0d", k),  {31'd0, done_w[k]},  32'd0);
      check($sformatf("reset_mis%0d", k),   {31'd0, mis_w[k]},   32'd0);
      check($sformatf("reset_rd%0d", k),    rd_w[k],             32'd0);
    end
    @(posedge clk); #1;

    // Zero-latency instance: completes in the request cycle without stalling.
    disp_idx = 6'd4;
    access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8BADF00D, rd, mis, stalls, seen);
    check("l0_sw_seen", {31'd0, seen}, 32'd1);
    check("l0_sw_stalls", stalls, 32'd0);
    @(negedge clk);
    check("l0_disp_after_sw", disp_w[0], 32'h8BADF00D);
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis, stalls, seen);
    check("l0_lw_seen", {31'd0, seen}, 32'd1);
    check("l0_lw_stalls", stalls, 32'd0);
    check("l0_lw_data", rd, 32'h8BADF00D);
    @(negedge clk);
    check("l0_rd_held", rd_w[0], 32'h8BADF00D);
    @(posedge clk); #1;

    // Two-wait-state instance: back-to-back table of accesses.
    last_ld = 32'd0;
    for (int i = 0; i < 24; i++) begin
      access(1, vecs[i].r, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd,
             rd, mis, stalls, seen);
      check($sformatf("v%0d_seen", i),   {31'd0, seen}, 32'd1);
      check($sformatf("v%0d_stalls", i), stalls, 32'd2);
      check($sformatf("v%0d_rd", i),     rd, vecs[i].exp_rd);
      check($sformatf("v%0d_mis", i),    {31'd0, mis}, {31'd0, vecs[i].exp_mis});
      if (vecs[i].r && !vecs[i].w) last_ld = vecs[i].exp_rd;
    end
    disp_idx = 6'd2;
    @(negedge clk);
    check("l2_rd_held", rd_w[1], last_ld);
    check("l2_idle_stall", {31'd0, stall_w[1]}, 32'd0);
    check("l2_idle_done", {31'd0, done_w[1]}, 32'd0);
    check("l2_disp_w2", disp_w[1], 32'h00000077);
    disp_idx = 6'd1;
    #1 check("l2_disp_w1_wrap", disp_w[1], 32'h5A5A5A5A);
    disp_idx = 6'd8;
    #1 check("l2_disp_w8", disp_w[1], 32'hBEEFAA01);
    @(posedge clk); #1;

    // Three-wait-state instance: store request dropped after acceptance still commits.
    mr = 1'b0; mw = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h0C; wdata = 32'h12345678; sel = 2'd2;
    @(posedge clk); #1;
    mw = 1'b0;
    seen = 1'b0; cyc = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (done_w[2]) seen = 1'b1; else cyc++;
      @(posedge clk); #1;
    end
    check("drop_seen", {31'd0, seen}, 32'd1);
    check("drop_cycles", cyc, 32'd2);
    disp_idx = 6'd3;
    #1 check("drop_commit", disp_w[2], 32'h12345678);

    // Reset asserted while the store is waiting: nothing commits, memory cleared.
    disp_idx = 6'd2;
    mw = 1'b1; addr = 32'h08; wdata = 32'hFFFFFFFF; sel = 2'd2;
    @(posedge clk); #1;
    rst = 1'b1; mw = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_stall", {31'd0, stall_w[2]}, 32'd0);
    check("rst_mid_done", {31'd0, done_w[2]}, 32'd0);
    check("rst_mid_rd", rd_w[2], 32'd0);
    cyc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_w[2] || stall_w[2]) cyc++;
    end
    check("rst_mid_no_late_done", cyc, 32'd0);
    acc = 32'd0;
    for (int i = 0; i < 64; i++) begin
      disp_idx = 6'(i);
      #1 acc = acc | disp_w[2];
    end
    check("rst_mid_all_zero", acc, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
